ad_ip_jesd204_tpl_adc_deframer: RTL and testbench

// Receive-side transport-layer deframer: the counterpart of the TPL DAC framer. It sits between
// the JESD204 RX link layer and the ADC TPL datapath. It realigns incoming lane octets to frame

---
 rtl/ad_ip_jesd204_tpl_adc_deframer.sv | 169 ++++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_adc_deframer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_deframer.sv
// JESD204 RX transport-layer deframer: realigns lane octets to frame starts
// reported by link_sof, then unpacks frames into sign-extended 16-bit samples.

module ad_ip_jesd204_tpl_adc_deframer_lane #(
  parameter int OPB = 4,
  parameter int OW  = 2
) (
  input  logic [OPB*8-1:0] prev_i,
  input  logic [OPB*8-1:0] cur_i,
  input  logic [OW-1:0]    offset_i,
  output logic [OPB*8-1:0] aligned_o
);
  // Aligned octet j is octet (offset+j) of the {cur, prev} octet sequence.
  always_comb begin
    aligned_o = '0;
    for (int j = 0; j < OPB; j++) begin
      if (int'(offset_i) + j < OPB)
        aligned_o[j*8 +: 8] = prev_i[(int'(offset_i) + j)*8 +: 8];
      else
        aligned_o[j*8 +: 8] = cur_i[(int'(offset_i) + j - OPB)*8 +: 8];
    end
  end
endmodule

module ad_ip_jesd204_tpl_adc_deframer #(
  parameter int NUM_LANES            = 4,
  parameter int NUM_CHANNELS         = 2,
  parameter int SAMPLES_PER_FRAME    = 1,
  parameter int CONVERTER_RESOLUTION = 16,
  parameter int BITS_PER_SAMPLE      = 16,
  parameter int OCTETS_PER_BEAT      = 4
) (
  input  logic                                                  link_clk,
  input  logic                                                  link_reset,
  input  logic                                                  link_valid,
  input  logic [OCTETS_PER_BEAT-1:0]                            link_sof,
  input  logic [NUM_LANES*8*OCTETS_PER_BEAT-1:0]                link_data,
  output logic                                                  link_ready,
  output logic                                                  adc_valid,
  output logic [NUM_LANES*OCTETS_PER_BEAT*8/BITS_PER_SAMPLE*16-1:0] adc_data,
  output logic                                                  status_locked,
  output logic                                                  status_align_err,
  output logic [7:0]                                            status_err_cnt
);
  localparam int L   = NUM_LANES;
  localparam int M   = NUM_CHANNELS;
  localparam int S   = SAMPLES_PER_FRAME;
  localparam int N   = CONVERTER_RESOLUTION;
  localparam int NP  = BITS_PER_SAMPLE;
  localparam int OPB = OCTETS_PER_BEAT;
  localparam int F   = M*S*NP/(8*L);
  localparam int DPW = OPB*8*L/(M*NP);
  localparam int FPB = OPB/F;
  localparam int FB  = F*8*L;
  localparam int NK  = (N > 16) ? 16 : N;
  localparam int OW  = (OPB > 1) ? $clog2(OPB) : 1;
  localparam logic [OW-1:0] FMASK = OW'(F-1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                    state_q, state_d;
  logic [OW-1:0]             offset_q, offset_d;
  logic [7:0]                err_cnt_q, err_cnt_d;
  logic                      align_err_q, align_err_d;
  logic                      adc_valid_q, adc_valid_d;
  logic                      ready_q, prev_valid_q;
  logic [L-1:0][OPB*8-1:0]   prev_q, cur, aligned;
  logic [M*DPW*16-1:0]       adc_data_q, unpacked;
  logic [FPB-1:0][FB-1:0]    frames;
  logic [OW-1:0]             sof_idx;
  logic                      sof_any;

  assign cur     = link_data;
  assign sof_any = |link_sof;

  always_comb begin
    sof_idx = '0;
    for (int i = OPB-1; i >= 0; i--)
      if (link_sof[i]) sof_idx = OW'(i);
  end

  // Frame phase only matters modulo F; an SOF at any frame start of the
  // current phase is consistent and leaves the offset alone.
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    err_cnt_d   = err_cnt_q;
    align_err_d = 1'b0;
    if (link_valid && sof_any) begin
      case (state_q)
        HUNT: begin
          state_d  = LOCKED;
          offset_d = sof_idx;
        end
        default: begin
          if ((sof_idx & FMASK) != (offset_q & FMASK)) begin
            align_err_d = 1'b1;
            offset_d    = sof_idx;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      endcase
    end
    adc_valid_d = link_valid && prev_valid_q && (state_q == LOCKED) && !align_err_d;
  end

  for (genvar l = 0; l < L; l++) begin : g_lane
    ad_ip_jesd204_tpl_adc_deframer_lane #(.OPB(OPB), .OW(OW)) u_lane (
      .prev_i    (prev_q[l]),
      .cur_i     (cur[l]),
      .offset_i  (offset_q),
      .aligned_o (aligned[l])
    );
  end

  // Frame k: lane 0 octets k*F.., then lane 1, ...; first octet lands at the MSB.
  always_comb begin
    frames = '0;
    for (int k = 0; k < FPB; k++)
      for (int l = 0; l < L; l++)
        for (int o = 0; o < F; o++)
          frames[k][FB-1-(l*F+o)*8 -: 8] = aligned[l][(k*F+o)*8 +: 8];
  end

  function automatic logic [15:0] to_s16(input logic [NP-1:0] w);
    logic signed [15:0] t;
    t = 16'(w) << (16 - NP);
    return 16'(t >>> (16 - NK));
  endfunction

  always_comb begin
    unpacked = '0;
    for (int k = 0; k < FPB; k++)
      for (int c = 0; c < M; c++)
        for (int s = 0; s < S; s++)
          unpacked[(c*DPW + k*S + s)*16 +: 16] = to_s16(frames[k][FB-1-(c*S+s)*NP -: NP]);
  end

  always_ff @(posedge link_clk) begin
    if (link_reset) begin
      state_q      <= HUNT;
      offset_q     <= '0;
      err_cnt_q    <= '0;
      align_err_q  <= 1'b0;
      adc_valid_q  <= 1'b0;
      adc_data_q   <= '0;
      ready_q      <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_q       <= '0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      err_cnt_q    <= err_cnt_d;
      align_err_q  <= align_err_d;
      adc_valid_q  <= adc_valid_d;
      ready_q      <= 1'b1;
      prev_valid_q <= link_valid;
      if (adc_valid_d) adc_data_q <= unpacked;
      if (link_valid)  prev_q     <= cur;
    end
  end

  assign link_ready       = ready_q;
  assign adc_valid        = adc_valid_q;
  assign adc_data         = adc_data_q;
  assign status_locked    = (state_q == LOCKED);
  assign status_align_err = align_err_q;
  assign status_err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_deframer.sv
// Bench for the RX deframer (L=2, M=2, S=1, NP=16, OPB=4): one N=16 and one
// N=12 instance share stimulus and are compared to a beat-level octet model.

module tb_ad_ip_jesd204_tpl_adc_deframer;
  logic        clk = 1'b0;
  logic        link_reset, link_valid;
  logic [3:0]  link_sof;
  logic [63:0] link_data;

  logic        ready16, aval16, lock16, aerr16;
  logic [63:0] adata16;
  logic [7:0]  cnt16;
  logic        ready12, aval12, lock12, aerr12;
  logic [63:0] adata12;
  logic [7:0]  cnt12;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit          m_ready, m_locked, m_pv, m_aval, m_err;
  int          m_off, m_cnt;
  logic [63:0] m_prev, m_adata, m_adata12;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_adc_deframer #(
    .NUM_LANES(2), .NUM_CHANNELS(2), .SAMPLES_PER_FRAME(1),
    .CONVERTER_RESOLUTION(16), .BITS_PER_SAMPLE(16), .OCTETS_PER_BEAT(4)
  ) dut (
    .link_clk(clk), .link_reset(link_reset), .link_valid(link_valid),
    .link_sof(link_sof), .link_data(link_data), .link_ready(ready16),
    .adc_valid(aval16), .adc_data(adata16), .status_locked(lock16),
    .status_align_err(aerr16), .status_err_cnt(cnt16)
  );

  ad_ip_jesd204_tpl_adc_deframer #(
    .NUM_LANES(2), .NUM_CHANNELS(2), .SAMPLES_PER_FRAME(1),
    .CONVERTER_RESOLUTION(12), .BITS_PER_SAMPLE(16), .OCTETS_PER_BEAT(4)
  ) dut12 (
    .link_clk(clk), .link_reset(link_reset), .link_valid(link_valid),
    .link_sof(link_sof), .link_data(link_data), .link_ready(ready12),
    .adc_valid(aval12), .adc_data(adata12), .status_locked(lock12),
    .status_align_err(aerr12), .status_err_cnt(cnt12)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Rebuild the aligned octet stream from two beats, cut frames, form samples.
  function automatic logic [63:0] unpack(input logic [63:0] pv, input logic [63:0] cu,
                                         input int off, input bit n12);
    logic [7:0]  al [2][4];
    logic [7:0]  st [4];
    logic [15:0] w;
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < 2; l++)
      for (int j = 0; j < 4; j++)
        al[l][j] = (off + j < 4) ? pv[(l*4 + off + j)*8 +: 8] : cu[(l*4 + off + j - 4)*8 +: 8];
    for (int k = 0; k < 2; k++) begin
      st[0] = al[0][2*k]; st[1] = al[0][2*k+1];
      st[2] = al[1][2*k]; st[3] = al[1][2*k+1];
      for (int c = 0; c < 2; c++) begin
        w = {st[2*c], st[2*c+1]};
        if (n12) w = $signed(w) >>> 4;
        r[(c*2 + k)*16 +: 16] = w;
      end
    end
    return r;
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ".ready"},   ready16, 64'(m_ready));
    chk({ph, ".locked"},  lock16,  64'(m_locked));
    chk({ph, ".aerr"},    aerr16,  64'(m_err));
    chk({ph, ".errcnt"},  cnt16,   64'(m_cnt));
    chk({ph, ".valid"},   aval16,  64'(m_aval));
    chk({ph, ".data"},    adata16, m_adata);
    chk({ph, ".ready12"}, ready12, 64'(m_ready));
    chk({ph, ".lock12"},  lock12,  64'(m_locked));
    chk({ph, ".aerr12"},  aerr12,  64'(m_err));
    chk({ph, ".cnt12"},   cnt12,   64'(m_cnt));
    chk({ph, ".valid12"}, aval12,  64'(m_aval));
    chk({ph, ".data12"},  adata12, m_adata12);
  endtask

  task automatic do_reset(input string ph);
    link_reset = 1'b1; link_valid = 1'b0; link_sof = '0;
    @(posedge clk); #1;
    m_ready = 0; m_locked = 0; m_pv = 0; m_aval = 0; m_err = 0;
    m_off = 0; m_cnt = 0; m_prev = '0; m_adata = '0; m_adata12 = '0;
    check_all(ph);
    link_reset = 1'b0;
  endtask

  task automatic step(input string ph, input bit v, input logic [3:0] sof, input logic [63:0] d);
    int lo;
    bit nl, er;
    int no;
    link_valid = v; link_sof = sof; link_data = d;
    @(posedge clk); #1;
    lo = -1;
    for (int i = 3; i >= 0; i--) if (sof[i]) lo = i;
    nl = m_locked; no = m_off; er = 0;
    if (v && lo >= 0) begin
      if (!m_locked) begin
        nl = 1; no = lo;
      end else if ((lo % 2) != (m_off % 2)) begin
        er = 1; no = lo;
        if (m_cnt < 255) m_cnt++;
      end
    end
    m_aval = v && m_pv && m_locked && !er;
    if (m_aval) begin
      m_adata   = unpack(m_prev, d, m_off, 0);
      m_adata12 = unpack(m_prev, d, m_off, 1);
    end
    if (v) m_prev = d;
    m_pv = v; m_locked = nl; m_off = no; m_err = er; m_ready = 1;
    check_all(ph);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [3:0]  even_sof [6];
    logic [3:0]  odd_sof  [4];
    logic [63:0] held;
    even_sof = '{4'b0000, 4'b0000, 4'b0101, 4'b0100, 4'b0001, 4'b1100};
    odd_sof  = '{4'b0000, 4'b0010, 4'b1010, 4'b1110};
    link_reset = 1'b1; link_valid = 1'b0; link_sof = '0; link_data = '0;
    do_reset("rst");
    do_reset("rst2");

    // no SOF: never locks, never produces data
    for (int i = 0; i < 10; i++) step("nosof", 1'b1, 4'b0000, rnd64());
    chk("t1.locked", lock16, 64'd0);
    chk("t1.ready", ready16, 64'd1);

    // lock at offset 0 and check first samples two edges later
    step("lock", 1'b1, 4'b0101, 64'h44332211_DDCCBBAA);
    step("lock2", 1'b1, 4'b0000, rnd64());
    chk("t2.data", adata16, 64'h3344_1122_CCDD_AABB);
    chk("t2.valid", aval16, 64'd1);

    // SOF at another frame start of the same phase is not an error
    step("samephase", 1'b1, 4'b0100, rnd64());
    for (int i = 0; i < 20; i++)
      step("even", 1'b1, even_sof[$urandom_range(0, 5)], rnd64());
    chk("t3.errcnt", cnt16, 64'd0);

    // stream slips by one octet
    step("slipA", 1'b1, 4'b1010, 64'h13121110_03020100);
    chk("t4.aerr", aerr16, 64'd1);
    chk("t4.cnt", cnt16, 64'd1);
    chk("t4.valid", aval16, 64'd0);
    step("slipB", 1'b1, 4'b0000, 64'h17161514_07060504);
    chk("t4.aerr_end", aerr16, 64'd0);
    chk("t4.realigned", adata16, 64'h1314_1112_0304_0102);
    for (int i = 0; i < 10; i++)
      step("odd", 1'b1, odd_sof[$urandom_range(0, 3)], rnd64());

    // single-cycle gap costs two output beats, data held
    held = adata16;
    step("gap", 1'b0, 4'b0000, rnd64());
    chk("t5.gap0", aval16, 64'd0);
    step("gap1", 1'b1, 4'b0000, rnd64());
    chk("t5.gap1", aval16, 64'd0);
    chk("t5.held", adata16, held);
    step("gap2", 1'b1, 4'b0000, rnd64());
    chk("t5.resume", aval16, 64'd1);

    // mid-stream reset, then N=12 truncation/sign extension
    do_reset("midrst");
    step("n12a", 1'b1, 4'b0101, 64'h10000080_F07FF0FF);
    step("n12b", 1'b1, 4'b0000, rnd64());
    chk("t6.n12", adata12, 64'h0001_F800_07FF_FFFF);
    chk("t6.n16", adata16, 64'h0010_8000_7FF0_FFF0);

    // error counter saturation
    for (int i = 0; i < 300; i++)
      step("sat", 1'b1, (i % 2 == 0) ? 4'b0010 : 4'b0001, rnd64());
    chk("t6.sat", cnt16, 64'd255);

    // random traffic with gaps and occasional arbitrary SOF patterns
    for (int i = 0; i < 200; i++)
      step("rand", ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000, rnd64());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
